slave_spi: RTL and testbench
============================

// Module: slave_spi
// PURPOSE
//  SPI responder paired with the master SPI initiator (CPOL=0/CPHA=1, MSB first). Frame: CSN low, CMD byte, ADDR byte, N data bytes.
//  Oversamples SCK/CSN/MOSI in clk_i domain; bridges frames to a simple 8-bit register bus (write strobes, read requests).
//  Sits on the peripheral side of the board-level SPI link; requires clk_i >= 8x SCK.
// PARAMETERS
//  CPOL    1'b0   SCK idle level
//  CPHA    1'b1   1: drive MISO on leading edge, sample MOSI on trailing edge; 0: sample on leading, drive on trailing (first bit preloaded at CSN fall)
//  CMD_WR  8'h02  write command code
//  CMD_RD  8'h03  read command code
// PORTS
//  clk_i        in   1  system clock
//  rst_n        in   1  async reset, active low
//  spi_clk_i    in   1  SCK from master (async)
//  spi_csn_i    in   1  chip select, active low (async)
//  spi_mosi_i   in   1  master->slave data (async)
//  spi_miso_o   out  1  slave->master data
//  reg_addr_o   out  8  register address
//  reg_wdata_o  out  8  write data, valid with reg_wr_o
//  reg_wr_o     out  1  1-cycle write strobe
//  reg_rd_o     out  1  1-cycle read request; reg_rdata_i sampled exactly 1 clk_i later
//  reg_rdata_i  in   8  read data from register file (registered source)
//  rx_byte_o    out  8  last complete received byte
//  rx_vld_o     out  1  1-cycle pulse per complete byte (CMD, ADDR, DATA)
//  frame_done_o out  1  1-cycle pulse when CSN rises after >=1 complete byte
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; shift regs 0; sync flops: CSN=1, SCK=CPOL, MOSI=0.
//  Sync: 2-flop sync on SCK/CSN/MOSI, plus 1 history flop for edge detect; edge events lag pins by 2-3 clk_i.
//  States: IDLE -(CSN fall)-> CMD -(8 bits)-> ADDR -(8 bits)-> DATA -(8 bits)-> DATA; any state -(CSN high)-> IDLE.
//  Bit counter 3 bits, cleared on CSN fall; byte complete on 8th sample edge; rx_vld_o same cycle as rx_byte_o update.
//  CMD byte latched; ADDR byte loads reg_addr_o.
//  Write (CMD_WR): each complete DATA byte -> reg_wdata_o=byte, reg_wr_o=1 one cycle at current reg_addr_o; addr increments next cycle.
//  Read (CMD_RD): on ADDR complete, reg_rd_o pulse; rdata loaded into TX shift reg next cycle, shifted out during first DATA byte;
//   on each DATA byte complete, addr++ then reg_rd_o pulse (prefetch). MOSI in read DATA bytes: captured to rx_byte_o, no write.
//  Other CMD codes: bytes still received/rx_vld_o pulses; no reg_wr_o/reg_rd_o; MISO=0.
//  MISO: 0 during CMD/ADDR and when CSN high; TX shift on drive edge, MSB first.
//  Address arithmetic 8-bit, wraps 8'hFF->8'h00; no error flag.
//  CSN rise mid-byte: partial byte discarded, no strobes, no rx_vld_o; state IDLE within 3 clk_i.
//  CSN rise at byte boundary: frame_done_o pulse; new CSN fall restarts at CMD.
//  SCK edges while CSN high ignored. Simultaneous byte-complete and CSN rise in same cycle: byte completes first (strobes issue), then IDLE.
//  rst_n low mid-frame: immediate return to reset values; frame must restart with new CSN fall.
// CONFIGURATION
//  SPI_SLV_MISO_OE_EN defined: adds port spi_miso_oe_o (out,1), high only in read DATA bytes while CSN low; MISO=0 otherwise.
//  Not defined: no OE port; spi_miso_o driven continuously (0 outside read DATA), for point-to-point links.
// STRUCTURE
//  Package spi_pkg: state encoding (IDLE/CMD/ADDR/DATA), CMD_WR/CMD_RD defaults, CPOL/CPHA mode constants.
//  Sub-module spi_slv_sync: 2-flop synchronizer + rise/fall detect for SCK and CSN, synced MOSI; instanced once.
// TESTING (BFM: 50 MHz clk_i, 1 MHz SCK, mode CPOL=0/CPHA=1)
//  Write 02,10,A5,5A -> reg_wr_o @addr 10=A5, @11=5A; frame_done_o once; 4 rx_vld_o pulses.
//  Read 03,20 + 2 dummy, regfile[20]=3C,[21]=C3 -> MISO 3C,C3; reg_rd_o at 20,21,22.
//  Write 02,FF,11,22 -> writes @FF=11, @00=22 (wrap).
//  Write 02,40 then CSN high after 5 bits of data -> no reg_wr_o, no frame_done_o for partial; next frame clean.
//  CMD 7E,30,55 -> 3 rx_vld_o, zero reg_wr_o/reg_rd_o, MISO stays 0.
//  rst_n pulse mid-read -> outputs 0 immediately; following write frame 02,05,99 writes @05=99.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-bus responder: state encoding,
// default command codes and the default SPI mode (CPOL=0 / CPHA=1).
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    localparam logic [7:0] CMD_WR_DEF = 8'h02;
    localparam logic [7:0] CMD_RD_DEF = 8'h03;

    localparam logic CPOL_DEF = 1'b0;
    localparam logic CPHA_DEF = 1'b1;

    // Register addresses wrap 8'hFF -> 8'h00 silently.
    function automatic logic [7:0] addr_next(input logic [7:0] addr);
        return addr + 8'd1;
    endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// Brings the asynchronous SPI pins into the clk_i domain: two-flop
// synchronizers on SCK/CSN/MOSI plus a history flop on SCK and CSN so their
// edges appear as single-cycle pulses. All three pins see the same depth, so
// MOSI is aligned with the SCK edge that qualifies it.
module spi_slv_sync
    import spi_pkg::*;
#(
    parameter logic CPOL = CPOL_DEF
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic spi_clk_i,
    input  logic spi_csn_i,
    input  logic spi_mosi_i,
    output logic sck_rise,
    output logic sck_fall,
    output logic csn_rise,
    output logic csn_fall,
    output logic csn_lvl,
    output logic mosi
);

    logic sck_p0, sck_p1, sck_p2;
    logic csn_p0, csn_p1, csn_p2;
    logic mosi_p0, mosi_p1;

    // Synchronizer chains; reset to the idle bus levels so no edge is seen
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sck_p0  <= CPOL;
            sck_p1  <= CPOL;
            sck_p2  <= CPOL;
            csn_p0  <= 1'b1;
            csn_p1  <= 1'b1;
            csn_p2  <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sck_p0  <= spi_clk_i;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            csn_p0  <= spi_csn_i;
            csn_p1  <= csn_p0;
            csn_p2  <= csn_p1;
            mosi_p0 <= spi_mosi_i;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;
    assign csn_rise = csn_p1 & ~csn_p2;
    assign csn_fall = ~csn_p1 & csn_p2;
    assign csn_lvl  = csn_p1;
    assign mosi     = mosi_p1;

endmodule

// File: rtl/slave_spi.sv
// SPI responder bridging CMD/ADDR/DATA frames onto an 8-bit register bus.
// Write frames issue one reg_wr_o strobe per data byte with auto-increment;
// read frames prefetch reg_rdata_i into the TX shifter one byte ahead.
// Optional feature: define SPI_SLV_MISO_OE_EN to add spi_miso_oe_o for a
// shared MISO line (high only while read data is being shifted out).
module slave_spi
    import spi_pkg::*;
#(
    parameter logic       CPOL   = CPOL_DEF,
    parameter logic       CPHA   = CPHA_DEF,
    parameter logic [7:0] CMD_WR = CMD_WR_DEF,
    parameter logic [7:0] CMD_RD = CMD_RD_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       spi_clk_i,
    input  logic       spi_csn_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
`ifdef SPI_SLV_MISO_OE_EN
    output logic       spi_miso_oe_o,
`endif
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_wr_o,
    output logic       reg_rd_o,
    input  logic [7:0] reg_rdata_i,
    output logic [7:0] rx_byte_o,
    output logic       rx_vld_o,
    output logic       frame_done_o
);

    logic sck_rise, sck_fall, csn_rise, csn_fall, csn_lvl, mosi;

    spi_slv_sync #(.CPOL(CPOL)) u_sync (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .spi_clk_i  (spi_clk_i),
        .spi_csn_i  (spi_csn_i),
        .spi_mosi_i (spi_mosi_i),
        .sck_rise   (sck_rise),
        .sck_fall   (sck_fall),
        .csn_rise   (csn_rise),
        .csn_fall   (csn_fall),
        .csn_lvl    (csn_lvl),
        .mosi       (mosi)
    );

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] cmd;
    logic [7:0] tx;
    logic       miso_q;
    logic       got_byte;
    logic       rd_pend;
    logic       load_pend;

    logic       lead, trail, active;
    logic       sample_evt, drive_evt, done_now;
    logic [7:0] byte_now;
    logic       rd_data, miso_bit;

    assign lead       = CPOL ? sck_fall : sck_rise;
    assign trail      = CPOL ? sck_rise : sck_fall;
    // SCK edges only count inside a frame; IDLE also covers CSN-high time.
    assign active     = (state != ST_IDLE);
    assign sample_evt = active && (CPHA ? trail : lead);
    assign drive_evt  = active && (CPHA ? lead : trail);
    assign byte_now   = {rx_shift[6:0], mosi};
    assign done_now   = sample_evt && (bit_cnt == 3'd7);

    assign rd_data  = (state == ST_DATA) && (cmd == CMD_RD) && !csn_lvl;
    // CPHA=1 drives from a flop updated on the leading edge; CPHA=0 presents
    // the TX MSB directly so the first bit is valid before the first edge.
    assign miso_bit   = CPHA ? miso_q : tx[7];
    assign spi_miso_o = rd_data ? miso_bit : 1'b0;
`ifdef SPI_SLV_MISO_OE_EN
    assign spi_miso_oe_o = rd_data;
`endif

    // Frame FSM, byte assembly, register-bus strobes and TX shifting
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            bit_cnt      <= 3'd0;
            rx_shift     <= 8'd0;
            cmd          <= 8'd0;
            tx           <= 8'd0;
            miso_q       <= 1'b0;
            got_byte     <= 1'b0;
            rd_pend      <= 1'b0;
            load_pend    <= 1'b0;
            reg_addr_o   <= 8'd0;
            reg_wdata_o  <= 8'd0;
            reg_wr_o     <= 1'b0;
            reg_rd_o     <= 1'b0;
            rx_byte_o    <= 8'd0;
            rx_vld_o     <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            reg_wr_o     <= 1'b0;
            reg_rd_o     <= 1'b0;
            rx_vld_o     <= 1'b0;
            frame_done_o <= 1'b0;
            // Register file answers one cycle after the request is seen.
            load_pend    <= reg_rd_o;

            if (reg_wr_o)
                reg_addr_o <= addr_next(reg_addr_o);

            if (rd_pend) begin
                rd_pend    <= 1'b0;
                reg_addr_o <= addr_next(reg_addr_o);
                reg_rd_o   <= 1'b1;
            end

            // CPHA=0 skips the drive edge that follows a byte's last sample:
            // the next byte's MSB is already sitting in tx[7].
            if (drive_evt && state == ST_DATA && cmd == CMD_RD &&
                (CPHA || bit_cnt != 3'd0)) begin
                miso_q <= tx[7];
                tx     <= {tx[6:0], 1'b0};
            end

            if (load_pend)
                tx <= reg_rdata_i;

            if (csn_fall) begin
                state    <= ST_CMD;
                bit_cnt  <= 3'd0;
                rx_shift <= 8'd0;
                tx       <= 8'd0;
                miso_q   <= 1'b0;
                got_byte <= 1'b0;
                rd_pend  <= 1'b0;
            end else if (active) begin
                if (sample_evt) begin
                    bit_cnt  <= bit_cnt + 3'd1;
                    rx_shift <= byte_now;
                    if (bit_cnt == 3'd7) begin
                        rx_byte_o <= byte_now;
                        rx_vld_o  <= 1'b1;
                        got_byte  <= 1'b1;
                        case (state)
                            ST_CMD: begin
                                cmd   <= byte_now;
                                state <= ST_ADDR;
                            end
                            ST_ADDR: begin
                                reg_addr_o <= byte_now;
                                reg_rd_o   <= (cmd == CMD_RD);
                                state      <= ST_DATA;
                            end
                            ST_DATA: begin
                                if (cmd == CMD_WR) begin
                                    reg_wdata_o <= byte_now;
                                    reg_wr_o    <= 1'b1;
                                end else if (cmd == CMD_RD) begin
                                    rd_pend <= 1'b1;
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                // A byte finishing in the same cycle still completes above.
                if (csn_rise) begin
                    state <= ST_IDLE;
                    if (done_now || (got_byte && bit_cnt == 3'd0 && !sample_evt))
                        frame_done_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_slave_spi.sv
// Bench for slave_spi: bit-banged SPI master (CPOL=0/CPHA=1, 1 MHz SCK,
// 50 MHz clk_i), behavioural register file, and queue-based scoreboard for
// received bytes, write strobes and read requests.
module tb_slave_spi;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_clk_i = 1'b0;
    logic       spi_csn_i = 1'b1;
    logic       spi_mosi_i = 1'b0;
    logic       spi_miso_o;
`ifdef SPI_SLV_MISO_OE_EN
    logic       spi_miso_oe_o;
`endif
    logic [7:0] reg_addr_o;
    logic [7:0] reg_wdata_o;
    logic       reg_wr_o;
    logic       reg_rd_o;
    logic [7:0] reg_rdata_i;
    logic [7:0] rx_byte_o;
    logic       rx_vld_o;
    logic       frame_done_o;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_rd[$];
    logic [7:0] exp_rx[$];
    logic [7:0] mem[256];
    int         frames_seen = 0;
    int         exp_frames  = 0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #10 clk_i = ~clk_i;

    slave_spi dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .spi_clk_i    (spi_clk_i),
        .spi_csn_i    (spi_csn_i),
        .spi_mosi_i   (spi_mosi_i),
        .spi_miso_o   (spi_miso_o),
`ifdef SPI_SLV_MISO_OE_EN
        .spi_miso_oe_o(spi_miso_oe_o),
`endif
        .reg_addr_o   (reg_addr_o),
        .reg_wdata_o  (reg_wdata_o),
        .reg_wr_o     (reg_wr_o),
        .reg_rd_o     (reg_rd_o),
        .reg_rdata_i  (reg_rdata_i),
        .rx_byte_o    (rx_byte_o),
        .rx_vld_o     (rx_vld_o),
        .frame_done_o (frame_done_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Registered register-file read port
    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)
            reg_rdata_i <= 8'd0;
        else if (reg_rd_o)
            reg_rdata_i <= mem[reg_addr_o];
    end

    // Scoreboard: pop expectations as the DUT produces strobes
    always @(negedge clk_i) begin
        if (rx_vld_o) begin
            if (exp_rx.size() == 0) chk("rx_q", exp_rx.size(), 1);
            else chk("rx_byte", rx_byte_o, exp_rx.pop_front());
        end
        if (reg_wr_o) begin
            if (exp_wr.size() == 0) chk("wr_q", exp_wr.size(), 1);
            else begin
                wr_t w;
                w = exp_wr.pop_front();
                chk("wr_addr", reg_addr_o, w.a);
                chk("wr_data", reg_wdata_o, w.d);
            end
        end
        if (reg_rd_o) begin
            if (exp_rd.size() == 0) chk("rd_q", exp_rd.size(), 1);
            else chk("rd_addr", reg_addr_o, exp_rd.pop_front());
        end
        if (frame_done_o) frames_seen++;
    end

    // One SPI byte (or its first nbits), MSB first; MOSI driven on the rising
    // edge, MISO sampled on the falling edge
    task automatic spi_byte(input logic [7:0] txb, input int nbits, output logic [7:0] rxb);
        rxb = 8'd0;
        for (int i = 7; i >= 8 - nbits; i--) begin
            spi_clk_i  = 1'b1;
            spi_mosi_i = txb[i];
            #500;
            spi_clk_i  = 1'b0;
            rxb[i]     = spi_miso_o;
            #500;
        end
    endtask

    // Full frame of n bytes; expected MISO per byte in mx
    task automatic frame(input int n, input logic [7:0] tb[4], input logic [7:0] mx[4]);
        logic [7:0] r;
        spi_csn_i = 1'b0;
        #500;
        for (int i = 0; i < n; i++) begin
            exp_rx.push_back(tb[i]);
            spi_byte(tb[i], 8, r);
            chk("miso", r, mx[i]);
        end
        spi_csn_i = 1'b1;
        #1500;
    endtask

    task automatic end_check();
        chk("frames", frames_seen, exp_frames);
        chk("rx_left", exp_rx.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        chk("rd_left", exp_rd.size(), 0);
    endtask

    initial begin
        logic [7:0] r;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        mem[8'h20] = 8'h3C;
        mem[8'h21] = 8'hC3;
        mem[8'h50] = 8'h96;

        // Reset values
        #105;
        chk("rst_addr",  reg_addr_o, 0);
        chk("rst_wdata", reg_wdata_o, 0);
        chk("rst_ctl",   {reg_wr_o, reg_rd_o, rx_vld_o, frame_done_o, spi_miso_o}, 0);
        chk("rst_rx",    rx_byte_o, 0);
        rst_n = 1'b1;
        #200;

        // Write with auto-increment
        exp_wr.push_back('{8'h10, 8'hA5});
        exp_wr.push_back('{8'h11, 8'h5A});
        exp_frames++;
        frame(4, '{8'h02, 8'h10, 8'hA5, 8'h5A}, '{8'h00, 8'h00, 8'h00, 8'h00});
        end_check();

        // Read with prefetch
        exp_rd.push_back(8'h20);
        exp_rd.push_back(8'h21);
        exp_rd.push_back(8'h22);
        exp_frames++;
        frame(4, '{8'h03, 8'h20, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h3C, 8'hC3});
        end_check();

        // Address wrap
        exp_wr.push_back('{8'hFF, 8'h11});
        exp_wr.push_back('{8'h00, 8'h22});
        exp_frames++;
        frame(4, '{8'h02, 8'hFF, 8'h11, 8'h22}, '{8'h00, 8'h00, 8'h00, 8'h00});
        end_check();

        // CSN rise after 5 data bits: partial byte dropped, no frame_done
        spi_csn_i = 1'b0;
        #500;
        exp_rx.push_back(8'h02);
        spi_byte(8'h02, 8, r);
        exp_rx.push_back(8'h40);
        spi_byte(8'h40, 8, r);
        spi_byte(8'hFF, 5, r);
        spi_csn_i = 1'b1;
        #1500;
        end_check();

        // Next frame after the partial one is clean
        exp_wr.push_back('{8'h41, 8'h77});
        exp_frames++;
        frame(3, '{8'h02, 8'h41, 8'h77, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00});
        end_check();

        // Unknown command: bytes received, no bus activity, MISO quiet
        exp_frames++;
        frame(3, '{8'h7E, 8'h30, 8'h55, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00});
        end_check();

        // Reset in the middle of a read data byte
        exp_rd.push_back(8'h50);
        spi_csn_i = 1'b0;
        #500;
        exp_rx.push_back(8'h03);
        spi_byte(8'h03, 8, r);
        exp_rx.push_back(8'h50);
        spi_byte(8'h50, 8, r);
        spi_byte(8'h00, 4, r);
        chk("rd_part", r[7:4], 4'h9);
        rst_n = 1'b0;
        #1;
        chk("mid_addr", reg_addr_o, 0);
        chk("mid_rx",   rx_byte_o, 0);
        chk("mid_ctl",  {reg_wr_o, reg_rd_o, rx_vld_o, frame_done_o, spi_miso_o}, 0);
        spi_csn_i = 1'b1;
        #200;
        rst_n = 1'b1;
        #1500;
        end_check();

        exp_wr.push_back('{8'h05, 8'h99});
        exp_frames++;
        frame(3, '{8'h02, 8'h05, 8'h99, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00});
        end_check();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
